// File: rtl/muldiv_if.sv
// Request/response bundle between the execute stage and the multiply/divide unit.
// The unit owns HI/LO and raises busy/stall while an operation is in flight.
interface muldiv_if #(
    parameter int WIDTH = 32
) ();
    logic             start_i;
    logic [2:0]       op_i;
    logic [WIDTH-1:0] rs_i;
    logic [WIDTH-1:0] rt_i;
    logic             hilo_read_i;
    logic             flush_i;
    logic [WIDTH-1:0] hi_o;
    logic [WIDTH-1:0] lo_o;
    logic             busy_o;
    logic             done_o;
    logic             stall_o;

    modport master (
        output start_i, op_i, rs_i, rt_i, hilo_read_i, flush_i,
        input  hi_o, lo_o, busy_o, done_o, stall_o
    );

    modport slave (
        input  start_i, op_i, rs_i, rt_i, hilo_read_i, flush_i,
        output hi_o, lo_o, busy_o, done_o, stall_o
    );
endinterface

// File: rtl/muldiv_unit.sv
// Multi-cycle multiply/divide unit owning HI/LO: latency-configurable multiply,
// restoring radix-2 divide with a final sign-fix cycle, MTHI/MTLO, flush and stall.
module muldiv_unit #(
    parameter int WIDTH       = 32,
    parameter int MUL_LATENCY = 1
) (
    input  logic     clk,
    input  logic     rst_n,
    muldiv_if.slave  bus
);

    localparam logic [2:0] OP_MULT  = 3'd0;
    localparam logic [2:0] OP_MULTU = 3'd1;
    localparam logic [2:0] OP_DIV   = 3'd2;
    localparam logic [2:0] OP_DIVU  = 3'd3;
    localparam logic [2:0] OP_MTHI  = 3'd4;
    localparam logic [2:0] OP_MTLO  = 3'd5;

    localparam logic [1:0] S_IDLE    = 2'd0;
    localparam logic [1:0] S_MUL     = 2'd1;
    localparam logic [1:0] S_DIV     = 2'd2;
    localparam logic [1:0] S_DIV_FIX = 2'd3;

    localparam int CNT_MAX = (WIDTH > MUL_LATENCY) ? WIDTH : MUL_LATENCY;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);

    // Magnitude of a possibly-signed operand; -2^(W-1) maps to unsigned 2^(W-1).
    function automatic logic [WIDTH-1:0] magnitude(input logic [WIDTH-1:0] v,
                                                   input logic is_signed);
        return (is_signed && v[WIDTH-1]) ? (~v + 1'b1) : v;
    endfunction

    function automatic logic [WIDTH-1:0] cond_negate(input logic [WIDTH-1:0] v,
                                                     input logic neg);
        return neg ? (~v + 1'b1) : v;
    endfunction

    logic [1:0]       state;
    logic [CNT_W-1:0] cnt;
    logic             busy_q;
    logic             done_q;
    logic [WIDTH-1:0] hi_q;
    logic [WIDTH-1:0] lo_q;

    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;
    logic             mul_signed_q;
    logic [WIDTH-1:0] dsr_q;
    logic [WIDTH-1:0] quo_q;
    logic [WIDTH-1:0] rem_q;
    logic             neg_quo_q;
    logic             neg_rem_q;
    logic             div_zero_q;

    logic             accept;
    logic             div_signed;

    logic signed [2*WIDTH-1:0] a_ext;
    logic signed [2*WIDTH-1:0] b_ext;
    logic signed [2*WIDTH-1:0] product;

    logic [WIDTH:0]   trial;
    logic [WIDTH-1:0] rem_nxt;
    logic [WIDTH-1:0] quo_nxt;
    logic [WIDTH-1:0] hi_fix;
    logic [WIDTH-1:0] lo_fix;

    assign accept     = bus.start_i & ~busy_q & ~bus.flush_i;
    assign div_signed = (bus.op_i == OP_DIV);

    // Sign- or zero-extend to 2W so one signed multiplier covers MULT and MULTU.
    always_comb begin
        a_ext   = mul_signed_q ? {{WIDTH{a_q[WIDTH-1]}}, a_q} : {{WIDTH{1'b0}}, a_q};
        b_ext   = mul_signed_q ? {{WIDTH{b_q[WIDTH-1]}}, b_q} : {{WIDTH{1'b0}}, b_q};
        product = a_ext * b_ext;
    end

    always_comb begin
        trial = {rem_q, quo_q[WIDTH-1]} - {1'b0, dsr_q};
        if (!trial[WIDTH]) begin
            rem_nxt = trial[WIDTH-1:0];
            quo_nxt = {quo_q[WIDTH-2:0], 1'b1};
        end else begin
            rem_nxt = {rem_q[WIDTH-2:0], quo_q[WIDTH-1]};
            quo_nxt = {quo_q[WIDTH-2:0], 1'b0};
        end
    end

    // Divide-by-zero bypasses the magnitude result; overflow falls out naturally.
    always_comb begin
        if (div_zero_q) begin
            lo_fix = '1;
            hi_fix = a_q;
        end else begin
            lo_fix = cond_negate(quo_q, neg_quo_q);
            hi_fix = cond_negate(rem_q, neg_rem_q);
        end
    end

    always_ff @(posedge clk) begin
        if (accept) begin
            a_q          <= bus.rs_i;
            b_q          <= bus.rt_i;
            mul_signed_q <= (bus.op_i == OP_MULT);
            dsr_q        <= magnitude(bus.rt_i, div_signed);
            quo_q        <= magnitude(bus.rs_i, div_signed);
            rem_q        <= '0;
            neg_quo_q    <= div_signed & (bus.rs_i[WIDTH-1] ^ bus.rt_i[WIDTH-1]);
            neg_rem_q    <= div_signed & bus.rs_i[WIDTH-1];
            div_zero_q   <= (bus.rt_i == '0);
        end else if (state == S_DIV) begin
            rem_q <= rem_nxt;
            quo_q <= quo_nxt;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= S_IDLE;
            cnt    <= '0;
            busy_q <= 1'b0;
            done_q <= 1'b0;
            hi_q   <= '0;
            lo_q   <= '0;
        end else begin
            done_q <= 1'b0;
            if (bus.flush_i) begin
                state  <= S_IDLE;
                cnt    <= '0;
                busy_q <= 1'b0;
            end else begin
                case (state)
                    S_IDLE: begin
                        if (accept) begin
                            case (bus.op_i)
                                OP_MULT, OP_MULTU: begin
                                    state  <= S_MUL;
                                    busy_q <= 1'b1;
                                    cnt    <= CNT_W'(MUL_LATENCY - 1);
                                end
                                OP_DIV, OP_DIVU: begin
                                    state  <= S_DIV;
                                    busy_q <= 1'b1;
                                    cnt    <= CNT_W'(WIDTH - 1);
                                end
                                OP_MTHI: hi_q <= bus.rs_i;
                                OP_MTLO: lo_q <= bus.rs_i;
                                default: ;
                            endcase
                        end
                    end
                    S_MUL: begin
                        if (cnt == '0) begin
                            {hi_q, lo_q} <= product;
                            state        <= S_IDLE;
                            busy_q       <= 1'b0;
                            done_q       <= 1'b1;
                        end else begin
                            cnt <= cnt - 1'b1;
                        end
                    end
                    S_DIV: begin
                        if (cnt == '0) begin
                            state <= S_DIV_FIX;
                        end else begin
                            cnt <= cnt - 1'b1;
                        end
                    end
                    default: begin
                        hi_q   <= hi_fix;
                        lo_q   <= lo_fix;
                        state  <= S_IDLE;
                        busy_q <= 1'b0;
                        done_q <= 1'b1;
                    end
                endcase
            end
        end
    end

    assign bus.hi_o    = hi_q;
    assign bus.lo_o    = lo_q;
    assign bus.busy_o  = busy_q;
    assign bus.done_o  = done_q;
    assign bus.stall_o = busy_q & (bus.hilo_read_i | bus.start_i);

endmodule

// File: tb/tb_muldiv_unit.sv
// Directed bench for muldiv_unit: multiply, divide corner cases, MTHI/MTLO,
// flush, asynchronous reset and start-while-busy, with hand-computed results.
module tb_muldiv_unit;

    logic clk;
    logic rst_n;
    int   n_tests;
    int   n_fail;

    muldiv_if #(.WIDTH(32)) m0 ();
    muldiv_if #(.WIDTH(32)) m1 ();

    muldiv_unit #(.WIDTH(32), .MUL_LATENCY(1)) u0 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (m0.slave)
    );

    muldiv_unit #(.WIDTH(32), .MUL_LATENCY(4)) u1 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (m1.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Issue one op on u0, then count busy cycles, done pulses and stalled cycles.
    task automatic run_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                          output int bcyc, output int dcnt, output int scnt);
        m0.start_i = 1'b1;
        m0.op_i    = op;
        m0.rs_i    = a;
        m0.rt_i    = b;
        tick();
        m0.start_i = 1'b0;
        bcyc = 0;
        dcnt = 0;
        scnt = 0;
        while (m0.busy_o && bcyc < 200) begin
            bcyc++;
            if (m0.stall_o) scnt++;
            tick();
            if (m0.done_o) dcnt++;
        end
    endtask

    int bc, dc, sc;

    initial begin
        n_tests = 0;
        n_fail  = 0;
        rst_n   = 1'b0;
        m0.start_i = 1'b0; m0.op_i = 3'd7; m0.rs_i = '0; m0.rt_i = '0;
        m0.hilo_read_i = 1'b0; m0.flush_i = 1'b0;
        m1.start_i = 1'b0; m1.op_i = 3'd7; m1.rs_i = '0; m1.rt_i = '0;
        m1.hilo_read_i = 1'b0; m1.flush_i = 1'b0;
        tick();
        tick();
        check("rst_hi",   {32'd0, m0.hi_o}, 64'd0);
        check("rst_lo",   {32'd0, m0.lo_o}, 64'd0);
        check("rst_busy", {63'd0, m0.busy_o}, 64'd0);
        check("rst_done", {63'd0, m0.done_o}, 64'd0);
        rst_n = 1'b1;
        tick();

        // MULT signed
        run_op(3'd0, 32'hFFFF_FFFE, 32'd3, bc, dc, sc);
        check("mult_busy", 64'(bc), 64'd1);
        check("mult_hilo", {m0.hi_o, m0.lo_o}, 64'hFFFF_FFFF_FFFF_FFFA);
        tick();
        if (m0.done_o) dc++;
        check("mult_done", 64'(dc), 64'd1);

        // MULTU
        run_op(3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, bc, dc, sc);
        check("multu_hilo", {m0.hi_o, m0.lo_o}, 64'hFFFF_FFFE_0000_0001);

        // MULTU with four-cycle latency
        m1.start_i = 1'b1; m1.op_i = 3'd1; m1.rs_i = 32'hFFFF_FFFF; m1.rt_i = 32'hFFFF_FFFF;
        tick();
        m1.start_i = 1'b0;
        bc = 0;
        while (m1.busy_o && bc < 50) begin
            bc++;
            tick();
        end
        check("lat4_busy", 64'(bc), 64'd4);
        check("lat4_hilo", {m1.hi_o, m1.lo_o}, 64'hFFFF_FFFE_0000_0001);
        check("lat4_done", {63'd0, m1.done_o}, 64'd1);

        // DIV signed with MFHI/MFLO pressure
        m0.hilo_read_i = 1'b1;
        run_op(3'd2, 32'hFFFF_FFF9, 32'd2, bc, dc, sc);
        check("div_busy",  64'(bc), 64'd33);
        check("div_stall", 64'(sc), 64'd33);
        check("div_stall_off", {63'd0, m0.stall_o}, 64'd0);
        check("div_hilo", {m0.hi_o, m0.lo_o}, 64'hFFFF_FFFF_FFFF_FFFD);
        check("div_done", 64'(dc), 64'd1);
        m0.hilo_read_i = 1'b0;

        run_op(3'd3, 32'd100, 32'd0, bc, dc, sc);
        check("divu_zero_busy", 64'(bc), 64'd33);
        check("divu_zero_hilo", {m0.hi_o, m0.lo_o}, {32'd100, 32'hFFFF_FFFF});
        run_op(3'd2, 32'h8000_0000, 32'hFFFF_FFFF, bc, dc, sc);
        check("div_ovf_hilo", {m0.hi_o, m0.lo_o}, {32'd0, 32'h8000_0000});
        run_op(3'd3, 32'hFFFF_FFFF, 32'd16, bc, dc, sc);
        check("divu_hilo", {m0.hi_o, m0.lo_o}, {32'd15, 32'h0FFF_FFFF});
        run_op(3'd2, 32'd7, 32'hFFFF_FFFE, bc, dc, sc);
        check("div_negdsr_hilo", {m0.hi_o, m0.lo_o}, {32'd1, 32'hFFFF_FFFD});

        // MTHI / MTLO
        m0.start_i = 1'b1; m0.op_i = 3'd4; m0.rs_i = 32'h1234;
        tick();
        check("mthi_hi",   {32'd0, m0.hi_o}, 64'h1234);
        check("mthi_busy", {63'd0, m0.busy_o}, 64'd0);
        m0.op_i = 3'd5; m0.rs_i = 32'h5678;
        tick();
        m0.start_i = 1'b0;
        check("mtlo_hilo", {m0.hi_o, m0.lo_o}, {32'h1234, 32'h5678});
        check("mtlo_busy", {63'd0, m0.busy_o}, 64'd0);
        check("mtlo_done", {63'd0, m0.done_o}, 64'd0);

        // Flush a divide in its tenth busy cycle
        m0.start_i = 1'b1; m0.op_i = 3'd2; m0.rs_i = 32'd100; m0.rt_i = 32'd7;
        tick();
        m0.start_i = 1'b0;
        repeat (9) tick();
        check("pre_flush_busy", {63'd0, m0.busy_o}, 64'd1);
        m0.flush_i = 1'b1;
        tick();
        m0.flush_i = 1'b0;
        check("flush_busy", {63'd0, m0.busy_o}, 64'd0);
        check("flush_done", {63'd0, m0.done_o}, 64'd0);
        check("flush_hilo", {m0.hi_o, m0.lo_o}, {32'h1234, 32'h5678});
        m0.start_i = 1'b1; m0.op_i = 3'd0; m0.rs_i = 32'd5; m0.rt_i = 32'd6;
        tick();
        m0.start_i = 1'b0;
        check("post_flush_accept", {63'd0, m0.busy_o}, 64'd1);
        tick();
        check("post_flush_hilo", {m0.hi_o, m0.lo_o}, 64'd30);
        check("post_flush_done", {63'd0, m0.done_o}, 64'd1);
        tick();
        repeat (33) begin
            if (m0.done_o) n_fail++;
            tick();
        end

        // Asynchronous reset in the middle of a divide
        m0.start_i = 1'b1; m0.op_i = 3'd2; m0.rs_i = 32'd50; m0.rt_i = 32'd3;
        tick();
        m0.start_i = 1'b0;
        repeat (4) tick();
        rst_n = 1'b0;
        #1;
        check("arst_hilo", {m0.hi_o, m0.lo_o}, 64'd0);
        check("arst_busy", {63'd0, m0.busy_o}, 64'd0);
        #2;
        rst_n = 1'b1;
        tick();

        // start_i while busy is dropped, not queued
        m0.start_i = 1'b1; m0.op_i = 3'd3; m0.rs_i = 32'd20; m0.rt_i = 32'd3;
        tick();
        m0.op_i = 3'd0; m0.rs_i = 32'd99; m0.rt_i = 32'd99;
        check("busy_start_stall", {63'd0, m0.stall_o}, 64'd1);
        tick();
        m0.start_i = 1'b0;
        bc = 1;
        while (m0.busy_o && bc < 200) begin
            bc++;
            tick();
        end
        check("ignore_busy_len", 64'(bc), 64'd33);
        check("ignore_hilo", {m0.hi_o, m0.lo_o}, {32'd2, 32'd6});
        tick();
        tick();
        check("ignore_not_queued", {63'd0, m0.busy_o}, 64'd0);
        check("ignore_hilo_final", {m0.hi_o, m0.lo_o}, {32'd2, 32'd6});

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
